// File: rtl/stage_nhead_seq_pkg.sv
// Shared types and helpers for stage_nhead_seq.
// STAGE_SAT_EN selects clamping sat(); otherwise sat() wraps to the target width.
package stage_nhead_seq_pkg;

  typedef enum logic [2:0] {IDLE, ATTN, RES, MLP, DONE} stage_state_t;

  localparam int FRAC_DEF = 8;

  // Reduce a wide signed value to w bits; the caller truncates the result to w.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
`ifdef STAGE_SAT_EN
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/stage_nhead_seq_mac.sv
// Shared multiply-shift unit: p = sat((a*b) >>> FRAC).
// Saturation behaviour follows STAGE_SAT_EN through the package sat().
module stage_mac_unit
  import stage_nhead_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = FRAC_DEF
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_o
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a_i * b_i;
  assign p_o  = DATA_W'(sat(64'(prod >>> FRAC), DATA_W));

endmodule

// File: rtl/stage_nhead_seq.sv
// N-head attention + M-layer MLP stage with residuals, time-multiplexed on one MAC.
// Build option STAGE_SAT_EN: clamp every sat() instead of wrapping.
module stage_nhead_seq
  import stage_nhead_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC     = FRAC_DEF,
  parameter int NUM_HEAD = 4,
  parameter int NUM_MLP  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic signed [DATA_W-1:0]     i_stage,
  input  logic [NUM_HEAD*DATA_W-1:0]   w_head,
  input  logic [NUM_MLP*DATA_W-1:0]    w_mlp,
  input  logic [NUM_MLP*DATA_W-1:0]    b_mlp,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic signed [DATA_W-1:0]     o_stage,
  output logic                         end_s
);

  localparam int ACC_W = DATA_W + $clog2(NUM_HEAD) + 1;
  localparam int CNT_W = $clog2(NUM_HEAD > NUM_MLP ? NUM_HEAD : NUM_MLP) + 1;

  stage_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] x_q, x_d, r1_q, r1_d, y_q, y_d, o_stage_q, o_stage_d;
  logic end_s_q, end_s_d;

  logic signed [DATA_W-1:0] mac_a, mac_b, mac_p, b_sel, acc_sat, res_sum, mlp_z, y_new;
  logic last_head, last_mlp;

  assign last_head = (cnt_q == CNT_W'(NUM_HEAD - 1));
  assign last_mlp  = (cnt_q == CNT_W'(NUM_MLP - 1));

  // Operand mux: heads use (x, w_head[h]); layers use (y, w_mlp[k]).
  always_comb begin
    mac_a = x_q;
    mac_b = w_head[int'(cnt_q)*DATA_W +: DATA_W];
    b_sel = '0;
    if (state_q == MLP) begin
      mac_a = y_q;
      mac_b = w_mlp[int'(cnt_q)*DATA_W +: DATA_W];
      b_sel = b_mlp[int'(cnt_q)*DATA_W +: DATA_W];
    end
  end

  stage_mac_unit #(.DATA_W(DATA_W), .FRAC(FRAC)) u_mac (
    .a_i (mac_a),
    .b_i (mac_b),
    .p_o (mac_p)
  );

  assign acc_sat = DATA_W'(sat(64'(acc_q), DATA_W));
  assign res_sum = DATA_W'(sat(64'(x_q) + 64'(acc_sat), DATA_W));
  assign mlp_z   = DATA_W'(sat(64'(mac_p) + 64'(b_sel), DATA_W));
  assign y_new   = mlp_z[DATA_W-1] ? '0 : mlp_z;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)   state_d = ATTN;
      ATTN:    if (last_head) state_d = RES;
      RES:                    state_d = MLP;
      MLP:     if (last_mlp)  state_d = DONE;
      DONE:    if (o_ready)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
    o_stage = o_stage_q;
    end_s   = end_s_q;
  end

  always_comb begin
    x_d       = x_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    r1_d      = r1_q;
    y_d       = y_q;
    o_stage_d = o_stage_q;
    end_s_d   = (state_d == DONE) && (state_q != DONE);
    case (state_q)
      IDLE: if (i_valid) begin
        x_d   = i_stage;
        acc_d = '0;
        cnt_d = '0;
      end
      ATTN: begin
        acc_d = acc_q + ACC_W'(mac_p);
        cnt_d = last_head ? '0 : cnt_q + 1'b1;
      end
      RES: begin
        r1_d = res_sum;
        y_d  = res_sum;
      end
      MLP: begin
        y_d   = y_new;
        cnt_d = last_mlp ? '0 : cnt_q + 1'b1;
        if (last_mlp) o_stage_d = DATA_W'(sat(64'(y_new) + 64'(r1_q), DATA_W));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      r1_q      <= '0;
      y_q       <= '0;
      o_stage_q <= '0;
      end_s_q   <= 1'b0;
    end else begin
      x_q       <= x_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      r1_q      <= r1_d;
      y_q       <= y_d;
      o_stage_q <= o_stage_d;
      end_s_q   <= end_s_d;
    end
  end

endmodule

// File: tb/tb_stage_nhead_seq.sv
// Self-checking bench for stage_nhead_seq: a 2-head/2-layer and a 4-head/1-layer instance.
module tb_stage_nhead_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  logic a_iv, a_ir, a_or, a_ov, a_end;
  logic signed [15:0] a_x, a_os;
  logic [31:0] a_wh, a_wm, a_bm;

  logic b_iv, b_ir, b_or, b_ov, b_end;
  logic signed [15:0] b_x, b_os;
  logic [63:0] b_wh;
  logic [15:0] b_wm, b_bm;

  stage_nhead_seq #(.DATA_W(16), .FRAC(8), .NUM_HEAD(2), .NUM_MLP(2)) dut_a (
    .clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir), .i_stage(a_x),
    .w_head(a_wh), .w_mlp(a_wm), .b_mlp(a_bm),
    .o_valid(a_ov), .o_ready(a_or), .o_stage(a_os), .end_s(a_end));

  stage_nhead_seq #(.DATA_W(16), .FRAC(8), .NUM_HEAD(4), .NUM_MLP(1)) dut_b (
    .clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir), .i_stage(b_x),
    .w_head(b_wh), .w_mlp(b_wm), .b_mlp(b_bm),
    .o_valid(b_ov), .o_ready(b_or), .o_stage(b_os), .end_s(b_end));

  // Reference arithmetic on plain integers.
  function automatic longint sat16(input longint v);
`ifdef STAGE_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    longint t;
    t = v & 64'hFFFF;
    if (t >= 32768) t = t - 65536;
    return t;
`endif
  endfunction

  function automatic longint model(input longint x, input logic [255:0] wh,
                                   input logic [255:0] wm, input logic [255:0] bm,
                                   input int nh, input int nm);
    longint acc, r1, y, w, b, t;
    acc = 0;
    for (int h = 0; h < nh; h++) begin
      w = longint'($signed(wh[h*16 +: 16]));
      acc = acc + sat16((x * w) >>> 8);
    end
    r1 = sat16(x + sat16(acc));
    y = r1;
    for (int k = 0; k < nm; k++) begin
      w = longint'($signed(wm[k*16 +: 16]));
      b = longint'($signed(bm[k*16 +: 16]));
      t = sat16(sat16((y * w) >>> 8) + b);
      y = (t < 0) ? 0 : t;
    end
    return sat16(y + r1);
  endfunction

  function automatic logic [15:0] rnd(input int span);
    int v;
    v = int'($urandom_range(2 * span)) - span;
    return 16'(v);
  endfunction

  // Drive one sample through instance A with o_ready high; report latency, result, end_s pulses.
  task automatic xfer_a(input logic signed [15:0] x, input logic [31:0] wh, input logic [31:0] wm,
                        input logic [31:0] bm, output int lat, output logic signed [15:0] y,
                        output int ends, output bit tmo);
    int n;
    tmo = 0; ends = 0; lat = 0; y = '0;
    @(negedge clk);
    a_x = x; a_wh = wh; a_wm = wm; a_bm = bm; a_or = 1'b1; a_iv = 1'b1;
    n = 0;
    while (!a_ir && n < 50) begin @(negedge clk); n++; end
    if (!a_ir) begin tmo = 1; a_iv = 1'b0; return; end
    do begin
      @(negedge clk);
      if (lat == 0) a_iv = 1'b0;
      lat++;
      if (a_end) ends++;
    end while (!a_ov && lat < 50);
    if (!a_ov) tmo = 1;
    y = a_os;
    @(negedge clk);
    if (a_end) ends++;
  endtask

  task automatic xfer_b(input logic signed [15:0] x, input logic [63:0] wh, input logic [15:0] wm,
                        input logic [15:0] bm, output int lat, output logic signed [15:0] y,
                        output int ends, output bit tmo);
    int n;
    tmo = 0; ends = 0; lat = 0; y = '0;
    @(negedge clk);
    b_x = x; b_wh = wh; b_wm = wm; b_bm = bm; b_or = 1'b1; b_iv = 1'b1;
    n = 0;
    while (!b_ir && n < 50) begin @(negedge clk); n++; end
    if (!b_ir) begin tmo = 1; b_iv = 1'b0; return; end
    do begin
      @(negedge clk);
      if (lat == 0) b_iv = 1'b0;
      lat++;
      if (b_end) ends++;
    end while (!b_ov && lat < 50);
    if (!b_ov) tmo = 1;
    y = b_os;
    @(negedge clk);
    if (b_end) ends++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ncmp++;
    if (a_ir !== 1'b1 || a_ov !== 1'b0 || a_os !== 16'sd0 || a_end !== 1'b0) begin
      nfail++;
      $display("FAIL reset_a: got ir=%b ov=%b os=%0d end=%b want ir=1 ov=0 os=0 end=0", a_ir, a_ov, a_os, a_end);
    end
    ncmp++;
    if (b_ir !== 1'b1 || b_ov !== 1'b0 || b_os !== 16'sd0 || b_end !== 1'b0) begin
      nfail++;
      $display("FAIL reset_b: got ir=%b ov=%b os=%0d end=%b want ir=1 ov=0 os=0 end=0", b_ir, b_ov, b_os, b_end);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, ends; bit tmo; logic signed [15:0] y;
    xfer_a(16'sd256, {16'sd128, 16'sd128}, {16'sd256, 16'sd256}, {16'sd32, 16'sd16}, lat, y, ends, tmo);
    ncmp++; if (tmo || y !== 16'sd1072) begin nfail++; $display("FAIL basic_out: got %0d (tmo=%0d) want 1072", y, tmo); end
    ncmp++; if (lat != 6) begin nfail++; $display("FAIL basic_latency: got %0d want 6", lat); end
    ncmp++; if (ends != 1) begin nfail++; $display("FAIL basic_end_s: got %0d pulses want 1", ends); end
  endtask

  task automatic test_relu;
    int lat, ends; bit tmo; logic signed [15:0] y;
    xfer_a(16'sd256, {16'sd128, 16'sd128}, {16'sd256, 16'sd256}, {16'sd0, -16'sd2000}, lat, y, ends, tmo);
    ncmp++; if (tmo || y !== 16'sd512) begin nfail++; $display("FAIL relu_out: got %0d (tmo=%0d) want 512", y, tmo); end
  endtask

  task automatic test_sat;
    int lat, ends; bit tmo; logic signed [15:0] y, exp;
`ifdef STAGE_SAT_EN
    exp = 16'sd32767;
`else
    exp = 16'sd32765;
`endif
    xfer_a(16'sd32767, {16'sd256, 16'sd256}, 32'd0, 32'd0, lat, y, ends, tmo);
    ncmp++; if (tmo || y !== exp) begin nfail++; $display("FAIL sat_out: got %0d (tmo=%0d) want %0d", y, tmo, exp); end
  endtask

  task automatic test_backpressure;
    int n; logic signed [15:0] held, exp;
    @(negedge clk);
    a_x = 16'sd1000; a_wh = {rnd(600), rnd(600)}; a_wm = {rnd(600), rnd(600)}; a_bm = {rnd(3000), rnd(3000)};
    exp = 16'(model(longint'(a_x), 256'(a_wh), 256'(a_wm), 256'(a_bm), 2, 2));
    a_or = 1'b0; a_iv = 1'b1;
    n = 0;
    while (!a_ir && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    a_iv = 1'b0;
    n = 0;
    while (!a_ov && n < 50) begin @(negedge clk); n++; end
    held = a_os;
    ncmp++; if (a_ov !== 1'b1 || held !== exp) begin nfail++; $display("FAIL bp_out: got ov=%b os=%0d want ov=1 os=%0d", a_ov, held, exp); end
    a_iv = 1'b1; a_x = -16'sd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ncmp++;
      if (a_ov !== 1'b1 || a_os !== held || a_ir !== 1'b0 || a_end !== 1'b0) begin
        nfail++;
        $display("FAIL bp_hold%0d: got ov=%b os=%0d ir=%b end=%b want ov=1 os=%0d ir=0 end=0", i, a_ov, a_os, a_ir, a_end, held);
      end
    end
    a_or = 1'b1; a_iv = 1'b0;
    @(negedge clk);
    ncmp++; if (a_ov !== 1'b0 || a_ir !== 1'b1) begin nfail++; $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", a_ov, a_ir); end
  endtask

  task automatic test_reset_mid;
    int lat, ends; bit tmo; logic signed [15:0] y, x, exp; logic [31:0] wh, wm, bm;
    @(negedge clk);
    a_x = 16'sd3000; a_wh = {16'sd300, 16'sd200}; a_wm = {16'sd256, 16'sd256}; a_bm = 32'd0;
    a_or = 1'b1; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    ncmp++; if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_os !== 16'sd0) begin nfail++; $display("FAIL rstmid_state: got ov=%b ir=%b os=%0d want 0 1 0", a_ov, a_ir, a_os); end
    rst = 1'b0;
    x = 16'sd700; wh = {16'sd100, -16'sd50}; wm = {16'sd300, 16'sd128}; bm = {16'sd7, -16'sd3};
    exp = 16'(model(longint'(x), 256'(wh), 256'(wm), 256'(bm), 2, 2));
    xfer_a(x, wh, wm, bm, lat, y, ends, tmo);
    ncmp++; if (tmo || y !== exp || lat != 6) begin nfail++; $display("FAIL rstmid_next: got %0d lat=%0d want %0d lat=6", y, lat, exp); end
  endtask

  task automatic test_nhead4;
    int lat, ends; bit tmo; logic signed [15:0] y;
    xfer_b(-16'sd256, {16'sd256, 16'sd256, -16'sd256, 16'sd256}, 16'sd256, 16'sd0, lat, y, ends, tmo);
    ncmp++; if (tmo || y !== -16'sd768) begin nfail++; $display("FAIL nh4_out: got %0d (tmo=%0d) want -768", y, tmo); end
    ncmp++; if (lat != 7) begin nfail++; $display("FAIL nh4_latency: got %0d want 7", lat); end
    ncmp++; if (ends != 1) begin nfail++; $display("FAIL nh4_end_s: got %0d pulses want 1", ends); end
  endtask

  task automatic test_back_to_back;
    int acc_t[$]; int ov_t[$]; int n; logic signed [15:0] exp;
    @(negedge clk);
    a_x = 16'sd1234; a_wh = {16'sd90, 16'sd170}; a_wm = {16'sd200, 16'sd300}; a_bm = {16'sd50, 16'sd25};
    exp = 16'(model(longint'(a_x), 256'(a_wh), 256'(a_wm), 256'(a_bm), 2, 2));
    a_or = 1'b1; a_iv = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (a_iv && a_ir) acc_t.push_back(c);
      if (a_ov) begin
        ov_t.push_back(c);
        ncmp++; if (a_os !== exp) begin nfail++; $display("FAIL b2b_out: got %0d want %0d", a_os, exp); end
      end
      @(negedge clk);
    end
    a_iv = 1'b0;
    n = 0;
    while (!a_ir && n < 50) begin @(negedge clk); n++; end
    ncmp++; if (acc_t.size() < 4 || ov_t.size() < 3) begin nfail++; $display("FAIL b2b_count: got acc=%0d ov=%0d want >=4 >=3", acc_t.size(), ov_t.size()); end
    else begin
      for (int i = 1; i < 4; i++) begin
        ncmp++; if (acc_t[i] - acc_t[i-1] != 7) begin nfail++; $display("FAIL b2b_gap%0d: got %0d want 7", i, acc_t[i] - acc_t[i-1]); end
      end
      ncmp++; if (ov_t[0] - acc_t[0] != 6) begin nfail++; $display("FAIL b2b_latency: got %0d want 6", ov_t[0] - acc_t[0]); end
    end
  endtask

  task automatic test_random;
    int lat, ends; bit tmo; logic signed [15:0] y, x, exp;
    logic [31:0] wh, wm, bm; logic [63:0] wh4; logic [15:0] wm1, bm1;
    for (int i = 0; i < 24; i++) begin
      x = 16'($urandom);
      wh = {rnd(600), rnd(600)}; wm = {rnd(600), rnd(600)}; bm = {rnd(6000), rnd(6000)};
      exp = 16'(model(longint'(x), 256'(wh), 256'(wm), 256'(bm), 2, 2));
      xfer_a(x, wh, wm, bm, lat, y, ends, tmo);
      ncmp++;
      if (tmo || y !== exp || lat != 6 || ends != 1) begin
        nfail++;
        $display("FAIL rand_a%0d: got %0d lat=%0d ends=%0d want %0d lat=6 ends=1", i, y, lat, ends, exp);
      end
    end
    for (int i = 0; i < 12; i++) begin
      x = 16'($urandom);
      wh4 = {rnd(600), rnd(600), rnd(600), rnd(600)}; wm1 = rnd(600); bm1 = rnd(6000);
      exp = 16'(model(longint'(x), 256'(wh4), 256'(wm1), 256'(bm1), 4, 1));
      xfer_b(x, wh4, wm1, bm1, lat, y, ends, tmo);
      ncmp++;
      if (tmo || y !== exp || lat != 7 || ends != 1) begin
        nfail++;
        $display("FAIL rand_b%0d: got %0d lat=%0d ends=%0d want %0d lat=7 ends=1", i, y, lat, ends, exp);
      end
    end
  endtask

  initial begin
    a_iv = 1'b0; a_or = 1'b0; a_x = '0; a_wh = '0; a_wm = '0; a_bm = '0;
    b_iv = 1'b0; b_or = 1'b0; b_x = '0; b_wh = '0; b_wm = '0; b_bm = '0;
    test_reset;
    test_basic;
    test_relu;
    test_sat;
    test_backpressure;
    test_reset_mid;
    test_nhead4;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
